// File: rtl/csd_encoder_param.sv
// Serial binary-to-CSD (NAF) encoder: one signed digit per clock, LSB first, early stop on zero residual.
// Nonzero digits are kept in a readback buffer alongside +/- masks and a nonzero count.
//
// state | meaning
// IDLE  | waiting for start; previous result held
// SCAN  | one digit per edge until the residual is zero
// DONE  | single-cycle done pulse, then back to IDLE
module csd_encoder_param #(
    parameter int WIDTH = 8,
    localparam int NDIG = WIDTH + 1,
    localparam int IDXW = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signedMode,
    input  logic [WIDTH-1:0] dataIn,
    input  logic [IDXW-1:0]  rdAddr,
    output logic             busy,
    output logic             done,
    output logic [IDXW-1:0]  nzCount,
    output logic             isZero,
    output logic [NDIG-1:0]  csdPos,
    output logic [NDIG-1:0]  csdNeg,
    output logic [IDXW-1:0]  rdPos,
    output logic             rdSign,
    output logic             rdValid
);

    localparam int XW   = WIDTH + 2;
    localparam int NBUF = 2 ** IDXW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic signed [XW-1:0]    x_q;
    logic signed [XW-1:0]    x_adj;
    logic signed [XW-1:0]    x_d;
    logic [IDXW-1:0]         pos_q;
    logic [IDXW-1:0]         nz_q;
    logic [NDIG-1:0]         csd_pos_q;
    logic [NDIG-1:0]         csd_neg_q;
    logic [NDIG-1:0]         pos_mask;
    logic                    done_q;
    logic                    busy_q;
    logic                    digit_wr;
    logic [IDXW-1:0]         buf_pos_q [NBUF];
    logic                    buf_sgn_q [NBUF];

    // x[1:0]==01 takes a +1 digit, 11 takes a -1 digit, so the residual is even before the shift.
    always_comb begin
        x_adj = x_q;
        if (x_q[0]) begin
            if (x_q[1]) begin
                x_adj = x_q + XW'(1);
            end else begin
                x_adj = x_q - XW'(1);
            end
        end
        x_d = x_adj >>> 1;
    end

    assign pos_mask = NDIG'(1) << pos_q;
    assign digit_wr = (state_q == ST_SCAN) && (x_q != '0) && x_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            pos_q     <= '0;
            nz_q      <= '0;
            csd_pos_q <= '0;
            csd_neg_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (signedMode) begin
                            x_q <= {{2{dataIn[WIDTH-1]}}, dataIn};
                        end else begin
                            x_q <= {2'b00, dataIn};
                        end
                        pos_q     <= '0;
                        nz_q      <= '0;
                        csd_pos_q <= '0;
                        csd_neg_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (x_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        x_q   <= x_d;
                        pos_q <= pos_q + IDXW'(1);
                        if (x_q[0]) begin
                            nz_q <= nz_q + IDXW'(1);
                            if (x_q[1]) begin
                                csd_neg_q <= csd_neg_q | pos_mask;
                            end else begin
                                csd_pos_q <= csd_pos_q | pos_mask;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer contents are don't-care after reset; rdValid masks stale entries.
    always_ff @(posedge clk) begin
        if (digit_wr) begin
            buf_pos_q[nz_q] <= pos_q;
            buf_sgn_q[nz_q] <= x_q[1];
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign nzCount = nz_q;
    assign isZero  = (nz_q == '0);
    assign csdPos  = csd_pos_q;
    assign csdNeg  = csd_neg_q;
    assign rdPos   = buf_pos_q[rdAddr];
    assign rdSign  = buf_sgn_q[rdAddr];
    assign rdValid = (rdAddr < nz_q);

endmodule

// File: tb/tb_csd_encoder_param.sv
// Directed and random checks of csd_encoder_param (WIDTH=8): results, latency, readback, reset abort, start filtering.
module tb_csd_encoder_param;

    localparam int WIDTH = 8;
    localparam int NDIG  = WIDTH + 1;
    localparam int IDXW  = $clog2(WIDTH + 2);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             signedMode;
    logic [WIDTH-1:0] dataIn;
    logic [IDXW-1:0]  rdAddr;
    logic             busy;
    logic             done;
    logic [IDXW-1:0]  nzCount;
    logic             isZero;
    logic [NDIG-1:0]  csdPos;
    logic [NDIG-1:0]  csdNeg;
    logic [IDXW-1:0]  rdPos;
    logic             rdSign;
    logic             rdValid;

    typedef struct {
        logic [NDIG-1:0] p;
        logic [NDIG-1:0] n;
        logic [IDXW-1:0] nz;
        int              lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    csd_encoder_param #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signedMode (signedMode),
        .dataIn     (dataIn),
        .rdAddr     (rdAddr),
        .busy       (busy),
        .done       (done),
        .nzCount    (nzCount),
        .isZero     (isZero),
        .csdPos     (csdPos),
        .csdNeg     (csdNeg),
        .rdPos      (rdPos),
        .rdSign     (rdSign),
        .rdValid    (rdValid)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // NAF digit i = bit(i+1) of 3k minus bit(i+1) of k.
    function automatic void model(input logic [WIDTH-1:0] op, input bit sm,
                                  output logic [NDIG-1:0] p, output logic [NDIG-1:0] n,
                                  output logic [IDXW-1:0] nz, output int lat);
        longint k;
        longint h;
        int     msd;
        k   = sm ? longint'($signed(op)) : longint'(op);
        h   = 3 * k;
        p   = '0;
        n   = '0;
        nz  = '0;
        msd = -1;
        for (int i = 0; i < NDIG; i++) begin
            p[i] = h[i+1] & ~k[i+1];
            n[i] = ~h[i+1] & k[i+1];
            if (p[i] | n[i]) begin
                nz  = nz + IDXW'(1);
                msd = i;
            end
        end
        lat = msd + 2;
    endfunction

    // Called just after a clock edge with the DUT idle; returns within the first IDLE cycle after DONE.
    task automatic run_op(input logic [WIDTH-1:0] op, input bit sm,
                          input logic [NDIG-1:0] ep, input logic [NDIG-1:0] en,
                          input logic [IDXW-1:0] enz, input int elat,
                          input bit dbl, input bit start_in_done);
        exp_t e;
        int   k;
        bit   got;
        int   idx;
        e.p = ep; e.n = en; e.nz = enz; e.lat = elat;
        sbq.push_back(e);
        dataIn     = op;
        signedMode = sm;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        dataIn     = ~op;
        signedMode = ~sm;
        chk("busy_after_start", 32'(busy), 32'd1);
        got = 1'b0;
        k   = 0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) begin
                got = 1'b1;
            end else if (dbl && k == 1) begin
                start  = 1'b1;
                dataIn = 8'hAA;
            end else if (dbl && k == 2) begin
                start  = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) begin
            chk("done_timeout", 32'(done), 32'd1);
            sbq.delete();
            return;
        end
        e = sbq.pop_front();
        chk("latency", 32'(k), 32'(e.lat));
        chk("csdPos", 32'(csdPos), 32'(e.p));
        chk("csdNeg", 32'(csdNeg), 32'(e.n));
        chk("nzCount", 32'(nzCount), 32'(e.nz));
        chk("isZero", 32'(isZero), 32'(e.nz == '0));
        chk("busy_in_done", 32'(busy), 32'd0);
        if (start_in_done) begin
            start  = 1'b1;
            dataIn = 8'h01;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        if (start_in_done) begin
            chk("held_after_ignored_start", 32'(nzCount), 32'(e.nz));
        end
        idx = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (e.p[i] | e.n[i]) begin
                rdAddr = IDXW'(idx);
                #1;
                chk("rdValid_in", 32'(rdValid), 32'd1);
                chk("rdPos", 32'(rdPos), 32'(i));
                chk("rdSign", 32'(rdSign), 32'(e.n[i]));
                idx++;
            end
        end
        if (e.nz == '0) begin
            for (int a = 0; a < 2 ** IDXW; a++) begin
                rdAddr = IDXW'(a);
                #1;
                chk("rdValid_zero", 32'(rdValid), 32'd0);
            end
        end else begin
            rdAddr = e.nz;
            #1;
            chk("rdValid_out", 32'(rdValid), 32'd0);
        end
    endtask

    initial begin
        logic [NDIG-1:0] mp;
        logic [NDIG-1:0] mn;
        logic [IDXW-1:0] mnz;
        int              mlat;
        logic [WIDTH-1:0] rop;
        bit              rsm;
        bit              seen_done;

        reset      = 1'b0;
        start      = 1'b0;
        signedMode = 1'b0;
        dataIn     = '0;
        rdAddr     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nz", 32'(nzCount), 32'd0);
        chk("rst_isZero", 32'(isZero), 32'd1);
        chk("rst_csdPos", 32'(csdPos), 32'd0);
        chk("rst_csdNeg", 32'(csdNeg), 32'd0);
        chk("rst_rdValid", 32'(rdValid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(8'hFF, 1'b0, 9'h100, 9'h001, 4'd2, 10, 1'b0, 1'b0);
        run_op(8'h37, 1'b0, 9'h040, 9'h009, 4'd3, 8, 1'b0, 1'b0);
        run_op(8'h80, 1'b1, 9'h000, 9'h080, 4'd1, 9, 1'b0, 1'b0);
        run_op(8'h80, 1'b0, 9'h080, 9'h000, 4'd1, 9, 1'b0, 1'b0);
        run_op(8'hFF, 1'b1, 9'h000, 9'h001, 4'd1, 2, 1'b0, 1'b1);
        run_op(8'h00, 1'b0, 9'h000, 9'h000, 4'd0, 1, 1'b0, 1'b0);

        // Reset in the middle of a scan
        @(posedge clk); #1;
        dataIn     = 8'hFF;
        signedMode = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_nz", 32'(nzCount), 32'd0);
        chk("abort_csdNeg", 32'(csdNeg), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        run_op(8'h37, 1'b0, 9'h040, 9'h009, 4'd3, 8, 1'b0, 1'b0);

        // Second start during SCAN is ignored
        run_op(8'h37, 1'b0, 9'h040, 9'h009, 4'd3, 8, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            rop = WIDTH'($urandom_range(0, 255));
            rsm = 1'($urandom_range(0, 1));
            model(rop, rsm, mp, mn, mnz, mlat);
            run_op(rop, rsm, mp, mn, mnz, mlat, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
